// File: rtl/full_logic_nch.sv
// rtl/full_logic_nch.sv - one input FIFO routed by destination bits into NCH output FIFOs
module full_logic_nch #(
    parameter int DATA_W    = 6,
    parameter int NCH       = 4,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [$clog2(OUT_DEPTH):0] thr_af,
    input  logic                      wr_enable,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [NCH-1:0]            pop,
    output logic [NCH*DATA_W-1:0]     data_out,
    output logic [NCH-1:0]            valid_out,
    output logic [NCH-1:0]            empty,
    output logic [NCH-1:0]            almost_full,
    output logic                      in_full,
    output logic [NCH:0]              error,
    output logic [1:0]                state
);
    localparam int SEL_W  = $clog2(NCH);
    localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [CNT_W-1:0] OUT_FULL = CNT_W'(OUT_DEPTH);
    localparam logic [IN_CW-1:0] IN_FULL  = IN_CW'(IN_DEPTH);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        thr_q, thr_d;
    logic [IN_AW-1:0]        in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IN_CW-1:0]        in_cnt_q, in_cnt_d;
    logic [OUT_AW-1:0]       out_wptr_q [NCH];
    logic [OUT_AW-1:0]       out_wptr_d [NCH];
    logic [OUT_AW-1:0]       out_rptr_q [NCH];
    logic [OUT_AW-1:0]       out_rptr_d [NCH];
    logic [CNT_W-1:0]        out_cnt_q  [NCH];
    logic [CNT_W-1:0]        out_cnt_d  [NCH];
    logic [NCH*DATA_W-1:0]   data_out_q, data_out_d;
    logic [NCH-1:0]          valid_q, valid_d;
    logic [NCH:0]            error_q, error_d;

    logic [DATA_W-1:0]       in_mem  [IN_DEPTH];
    logic [DATA_W-1:0]       out_mem [NCH][OUT_DEPTH];

    logic                    run, in_full_w, push, xfer, busy;
    logic [CNT_W-1:0]        thr_eff;
    logic [DATA_W-1:0]       in_head;
    logic [SEL_W-1:0]        dest;
    logic [NCH-1:0]          empty_w, af_w, pop_ok, xfer_ch;

    // Out-of-range thresholds (0 or above depth) fall back to the full depth.
    assign thr_eff   = (thr_q == '0 || thr_q > OUT_FULL) ? OUT_FULL : thr_q;
    assign run       = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign in_full_w = (in_cnt_q == IN_FULL);
    assign push      = run && wr_enable && !in_full_w;
    assign in_head   = in_mem[in_rptr_q];
    assign dest      = in_head[DATA_W-1 -: SEL_W];
    assign xfer      = run && (in_cnt_q != '0) && (out_cnt_q[dest] < thr_eff);
    assign busy      = (in_cnt_q != '0) || !(&empty_w);

    always_comb begin
        empty_w = '0;
        af_w    = '0;
        pop_ok  = '0;
        xfer_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            empty_w[i] = (out_cnt_q[i] == '0);
            af_w[i]    = (out_cnt_q[i] >= thr_eff);
            pop_ok[i]  = run && pop[i] && !empty_w[i];
            xfer_ch[i] = xfer && (dest == SEL_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)                   state_d = ST_INIT;
                else if (wr_enable || busy) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                    state_d = ST_INIT;
                else if (!busy && !wr_enable) state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
        thr_d = (state_q == ST_INIT) ? thr_af : thr_q;
    end

    always_comb begin
        in_wptr_d  = in_wptr_q + IN_AW'(push);
        in_rptr_d  = in_rptr_q + IN_AW'(xfer);
        in_cnt_d   = in_cnt_q + IN_CW'(push) - IN_CW'(xfer);
        error_d    = error_q;
        valid_d    = '0;
        data_out_d = data_out_q;
        if (run && wr_enable && in_full_w) error_d[0] = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            out_wptr_d[i] = out_wptr_q[i] + OUT_AW'(xfer_ch[i]);
            out_rptr_d[i] = out_rptr_q[i] + OUT_AW'(pop_ok[i]);
            out_cnt_d[i]  = out_cnt_q[i] + CNT_W'(xfer_ch[i]) - CNT_W'(pop_ok[i]);
            if (pop_ok[i]) begin
                valid_d[i] = 1'b1;
                data_out_d[i*DATA_W +: DATA_W] = out_mem[i][out_rptr_q[i]];
            end
            if (run && pop[i] && empty_w[i]) error_d[i+1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            thr_q      <= CNT_W'(OUT_DEPTH - 1);
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            data_out_q <= '0;
            valid_q    <= '0;
            error_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                out_wptr_q[i] <= '0;
                out_rptr_q[i] <= '0;
                out_cnt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            for (int i = 0; i < NCH; i++) begin
                out_wptr_q[i] <= out_wptr_d[i];
                out_rptr_q[i] <= out_rptr_d[i];
                out_cnt_q[i]  <= out_cnt_d[i];
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (push) in_mem[in_wptr_q] <= data_in;
        for (int i = 0; i < NCH; i++) begin
            if (xfer_ch[i]) out_mem[i][out_wptr_q[i]] <= in_head;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign empty       = empty_w;
    assign almost_full = af_w;
    assign in_full     = in_full_w;
    assign error       = error_q;
    assign state       = state_q;
endmodule
